fetch_stage: RTL

- Instruction-fetch end of the stall/flush protocol. It owns the PC register, issues requests to instruction memory and loads the IF/ID pipeline register.
- It obeys the hazard unit's pc_en and if_id_en and the execute stage's flush/redirect.
- It produces if_id_valid, which drives the hazard unit's valid_inst input.
- It sits between the instruction memory port and the decode stage.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/fetch_skid.sv | 50 +++++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - Shared fetch/decode pipeline types and constants
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_STALL = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - One-entry holding buffer for a fetched word that IF/ID cannot take yet
module fetch_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic            full,
    output logic [XLEN-1:0] skid_pc,
    output logic [XLEN-1:0] skid_inst
);

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;

    // A load always wins; the caller never asks for both in a flush cycle.
    always_comb begin
        full_d = full_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (load) begin
            full_d = 1'b1;
            pc_d   = load_pc;
            inst_d = load_inst;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            full_q <= full_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign full      = full_q;
    assign skid_pc   = pc_q;
    assign skid_inst = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, single-outstanding imem requester and IF/ID register loader
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic            if_id_en,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic            if_id_valid
);

    import pipeline_pkg::fetch_state_e;
    import pipeline_pkg::FETCH_BOOT;
    import pipeline_pkg::FETCH_REQ;
    import pipeline_pkg::FETCH_WAIT;
    import pipeline_pkg::FETCH_STALL;
    import pipeline_pkg::NOP_INST;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_inst_q, if_id_inst_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic            granted;
    logic            deliver;
    logic            skid_full;
    logic            skid_load;
    logic            skid_clear;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_inst;

    assign granted = (state_q == FETCH_REQ) && imem_gnt;
    // A response is only real if it is not the stale one after a redirect and not killed right now.
    assign deliver = (state_q == FETCH_WAIT) && imem_rvalid && !drop_q && !flush;

    assign skid_load  = deliver && (!if_id_en || skid_full);
    assign skid_clear = flush || (if_id_en && skid_full);

    fetch_skid #(
        .XLEN(XLEN)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .load_pc  (fetch_pc_q),
        .load_inst(imem_rdata),
        .full     (skid_full),
        .skid_pc  (skid_pc),
        .skid_inst(skid_inst)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_gnt) begin
                    pc_d       = pc_q + XLEN'(4);
                    fetch_pc_d = pc_q;
                    state_d    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    // The skid is empty here, so it stays empty unless IF/ID refuses the word.
                    if (pc_en && (drop_q || if_id_en)) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d = FETCH_STALL;
                    end
                end
            end
            FETCH_STALL: begin
                if (pc_en && !skid_full) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase

        if (flush) begin
            pc_d = redirect_pc;
            if (((state_q == FETCH_WAIT) && !imem_rvalid) || granted) begin
                drop_d  = 1'b1;
                state_d = FETCH_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = FETCH_REQ;
            end
        end
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;

        if (flush) begin
            if_id_valid_d = 1'b0;
        end else if (if_id_en) begin
            if (skid_full) begin
                if_id_pc_d    = skid_pc;
                if_id_inst_d  = skid_inst;
                if_id_valid_d = 1'b1;
            end else if (deliver) begin
                if_id_pc_d    = fetch_pc_q;
                if_id_inst_d  = imem_rdata;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_BOOT;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= '0;
            drop_q        <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= XLEN'(NOP_INST);
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            drop_q        <= drop_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_req    = (state_q == FETCH_REQ);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;

endmodule
